screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Top-level page controller that owns the 4-bit one-hot `status` bus driving the background, designer and game layers.
- Sequences TITLE -> PLAY -> WIN/LOSE -> TITLE on keyboard and game-logic events.
- Inserts a frame-counted fade-out/fade-in around every page change and holds game logic in reset across transitions into PLAY.
- Page changes happen only at a vertical-sync boundary, so no frame ever shows two pages.

Parameters:
- FADE_FRAMES, 32: frames per fade half. Power of two, at least 8.
- HOLD_FRAMES, 120: minimum frames on WIN/LOSE before a key is accepted.
- START_KEY, 8'h28: keycode that advances the page (Enter).

Ports:
- Clk  in  1  pixel clock, 25 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- VGA_VS  in  1  active-low vertical sync from the VGA controller; asynchronous to logic, synchronised internally.
- keycode  in  8  current keyboard code; 8'h00 means no key.
- win  in  1  level from game logic; sampled only in PLAY.
- lose  in  1  level from game logic; sampled only in PLAY.
- status  out  4  one-hot page: 0001 TITLE, 0010 PLAY, 0100 WIN, 1000 LOSE.
- fade_level  out  3  0 = full brightness, 7 = black; the colour mapper scales by it.
- page_change  out  1  one-cycle pulse when `status` changes.
- game_rst  out  1  active-high reset to game logic.

Behaviour:
- Reset (async assert, sync deassert): state TITLE, status=0001, fade_level=0, page_change=0, game_rst=1, all counters 0, key_pend=0.
- frame_tick:
  - VGA_VS passes through a 2-flop synchroniser.
  - frame_tick is a one-cycle pulse on the synchronised falling edge.
  - Latency is 3 Clk from the VGA_VS fall.
- Key edge:
  - key_hit is asserted when keycode==START_KEY this cycle and keycode!=START_KEY last cycle.
  - key_hit sets key_pend.
  - key_pend clears when consumed and on every state transition.
  - Holding the key fires only once.
- States: TITLE, PLAY, WIN, LOSE, FADE_OUT, FADE_IN. A `dest` register holds the target page.
- TITLE: on frame_tick with key_pend, set dest=PLAY and go to FADE_OUT.
- PLAY:
  - game_rst=0.
  - On frame_tick, win=1 gives dest=WIN; else lose=1 gives dest=LOSE. Either goes to FADE_OUT.
  - win has priority when win and lose are both set.
- WIN/LOSE:
  - hold_cnt increments on each frame_tick, saturating at HOLD_FRAMES.
  - A key_hit while hold_cnt<HOLD_FRAMES is discarded and does not set key_pend.
  - Once hold_cnt==HOLD_FRAMES, a frame_tick with key_pend sets dest=TITLE and goes to FADE_OUT.
- FADE_OUT:
  - status stays at the source page.
  - fade_cnt increments per frame_tick; fade_level = fade_cnt[MSB-:3].
  - On the frame_tick where fade_cnt==FADE_FRAMES-1: status<=dest, page_change=1 for that cycle, fade_cnt<=0, go to FADE_IN.
- FADE_IN:
  - fade_level = 7 - fade_cnt[MSB-:3].
  - On fade_cnt==FADE_FRAMES-1 at frame_tick: go to the dest state, fade_level<=0, hold_cnt<=0.
- game_rst: 1 in TITLE, WIN, LOSE, FADE_OUT and FADE_IN; 0 only in PLAY. The game therefore restarts clean on every PLAY entry.
- Keys and win/lose are ignored during both fade states.
- All outputs are registered. `status` changes only in the cycle after a frame_tick, i.e. in vertical blank.
- Reset asserted mid-fade returns to TITLE immediately and forces fade_level=0.
- Counter widths: fade_cnt is $clog2(FADE_FRAMES); hold_cnt is $clog2(HOLD_FRAMES+1). Neither wraps.

Decomposition:
- Package screen_pkg holds:
  - the state enum;
  - the status encodings STATUS_TITLE/PLAY/WIN/LOSE (4'b0001/0010/0100/1000), shared with the background, designer and colour-mapper layers;
  - the default START_KEY.
- One sub-module, frame_tick_gen: the VGA_VS synchroniser plus falling-edge pulse. It is reused by other frame-rate blocks.

Test Plan:
- Reset, then 3 frames with no key -> status=0001, fade_level=0, game_rst=1, page_change never pulses.
- Pulse keycode=8'h28 for 1 cycle in TITLE:
  - status stays 0001 for 32 frames while fade_level steps 0..7 (4 frames per step);
  - at frame 32, status=0010 with one page_change pulse;
  - fade_level then steps 7..0 over 32 frames;
  - game_rst falls only once fade_level returns to 0.
- PLAY with win=1 and lose=1 on the same frame -> dest=WIN; after 64 frames status=0100.
- In WIN, press Enter at frame 50 -> ignored. Press again at frame 121 -> fade begins, and status=0001 at 32 frames later.
- Hold keycode=8'h28 for 200 frames in TITLE:
  - exactly one transition occurs, ending in PLAY;
  - no second fade starts.
- Assert Reset_n=0 at mid FADE_OUT (fade_level=3) -> status=0001, fade_level=0 and game_rst=1 asynchronously.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared page-controller types: sequencer states, one-hot page encodings
// used by the background/designer/colour-mapper layers, and the default key.
package screen_pkg;

  typedef enum logic [2:0] {
    ST_TITLE,
    ST_PLAY,
    ST_WIN,
    ST_LOSE,
    ST_FADE_OUT,
    ST_FADE_IN
  } screen_state_t;

  localparam logic [3:0] STATUS_TITLE = 4'b0001;
  localparam logic [3:0] STATUS_PLAY  = 4'b0010;
  localparam logic [3:0] STATUS_WIN   = 4'b0100;
  localparam logic [3:0] STATUS_LOSE  = 4'b1000;

  localparam logic [7:0] START_KEY_DEFAULT = 8'h28;

  // One-hot status word shown while a page state is active.
  function automatic logic [3:0] status_of(input screen_state_t s);
    case (s)
      ST_PLAY: return STATUS_PLAY;
      ST_WIN:  return STATUS_WIN;
      ST_LOSE: return STATUS_LOSE;
      default: return STATUS_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/screen_sequencer_frame_tick_gen.sv
// VGA vertical-sync synchroniser with a registered one-cycle pulse on the
// synchronised falling edge (3 clocks after the VGA_VS fall).
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vga_vs,
  output logic frame_tick
);

  logic vs_meta;
  logic vs_sync;
  logic vs_prev;

  // Sync flops idle high (sync inactive) so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta    <= 1'b1;
      vs_sync    <= 1'b1;
      vs_prev    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= vga_vs;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_prev & ~vs_sync;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Page controller: TITLE -> PLAY -> WIN/LOSE -> TITLE with frame-counted
// fade-out/fade-in around each page change, all switching on frame ticks.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned FADE_FRAMES = 32,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter logic [7:0]  START_KEY   = START_KEY_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VGA_VS,
  input  logic [7:0] keycode,
  input  logic       win,
  input  logic       lose,
  output logic [3:0] status,
  output logic [2:0] fade_level,
  output logic       page_change,
  output logic       game_rst
);

  localparam int unsigned FW = $clog2(FADE_FRAMES);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES);

  screen_state_t state, state_n, dest, dest_n;
  logic [FW-1:0] fade_cnt, fade_cnt_n, fade_inc;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          key_pend, key_pend_n;
  logic [7:0]    key_prev;
  logic          key_hit;
  logic          frame_tick;
  logic [3:0]    status_n;
  logic [2:0]    fade_level_n;
  logic          page_change_n;

  frame_tick_gen u_frame_tick (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .vga_vs     (VGA_VS),
    .frame_tick (frame_tick)
  );

  assign key_hit  = (keycode == START_KEY) && (key_prev != START_KEY);
  assign fade_inc = fade_cnt + 1'b1;

  // State, counters and all outputs are registered here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_TITLE;
      dest        <= ST_TITLE;
      fade_cnt    <= '0;
      hold_cnt    <= '0;
      key_pend    <= 1'b0;
      key_prev    <= '0;
      status      <= STATUS_TITLE;
      fade_level  <= '0;
      page_change <= 1'b0;
      game_rst    <= 1'b1;
    end else begin
      state       <= state_n;
      dest        <= dest_n;
      fade_cnt    <= fade_cnt_n;
      hold_cnt    <= hold_cnt_n;
      key_pend    <= key_pend_n;
      key_prev    <= keycode;
      status      <= status_n;
      fade_level  <= fade_level_n;
      page_change <= page_change_n;
      game_rst    <= (state_n != ST_PLAY);
    end
  end

  // Next-state and next-output logic; every decision waits for frame_tick.
  always_comb begin
    state_n       = state;
    dest_n        = dest;
    fade_cnt_n    = fade_cnt;
    hold_cnt_n    = hold_cnt;
    key_pend_n    = key_pend;
    status_n      = status;
    fade_level_n  = fade_level;
    page_change_n = 1'b0;
    unique case (state)
      ST_TITLE: begin
        if (key_hit) key_pend_n = 1'b1;
        if (frame_tick && key_pend) begin
          dest_n  = ST_PLAY;
          state_n = ST_FADE_OUT;
        end
      end
      ST_PLAY: begin
        if (key_hit) key_pend_n = 1'b1;
        if (frame_tick && win) begin
          dest_n  = ST_WIN;
          state_n = ST_FADE_OUT;
        end else if (frame_tick && lose) begin
          dest_n  = ST_LOSE;
          state_n = ST_FADE_OUT;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (key_hit && hold_cnt == HOLD_LAST) key_pend_n = 1'b1;
        if (frame_tick) begin
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt_n = hold_cnt + 1'b1;
          end else if (key_pend) begin
            dest_n  = ST_TITLE;
            state_n = ST_FADE_OUT;
          end
        end
      end
      ST_FADE_OUT: begin
        if (frame_tick) begin
          if (fade_cnt == FADE_LAST) begin
            status_n      = status_of(dest);
            page_change_n = 1'b1;
            fade_cnt_n    = '0;
            fade_level_n  = 3'd7;
            state_n       = ST_FADE_IN;
          end else begin
            fade_cnt_n   = fade_inc;
            fade_level_n = fade_inc[FW-1 -: 3];
          end
        end
      end
      ST_FADE_IN: begin
        if (frame_tick) begin
          if (fade_cnt == FADE_LAST) begin
            fade_cnt_n   = '0;
            fade_level_n = '0;
            hold_cnt_n   = '0;
            state_n      = dest;
          end else begin
            fade_cnt_n   = fade_inc;
            fade_level_n = 3'd7 - fade_inc[FW-1 -: 3];
          end
        end
      end
      default: state_n = ST_TITLE;
    endcase
    // Any state change drops a pending key, including one hit this cycle.
    if (state_n != state) key_pend_n = 1'b0;
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: page/phase reference model checked every cycle,
// directed page walks with randomized frame timing, then random traffic.
module tb_screen_sequencer;

  localparam int F    = 32;
  localparam int HOLD = 120;
  localparam int P_STEADY = 0, P_OUT = 1, P_IN = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       VGA_VS = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic [3:0] status;
  logic [2:0] fade_level;
  logic       page_change;
  logic       game_rst;

  int errors = 0;
  int checks = 0;
  int pc_count = 0;
  bit rand_in = 1'b0;

  screen_sequencer #(.FADE_FRAMES(F), .HOLD_FRAMES(HOLD), .START_KEY(8'h28)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_VS(VGA_VS), .keycode(keycode),
    .win(win), .lose(lose), .status(status), .fade_level(fade_level),
    .page_change(page_change), .game_rst(game_rst)
  );

  always #20 Clk = ~Clk;

  // Reference model: page 0..3 = TITLE/PLAY/WIN/LOSE, phase steady/out/in.
  int       m_page, m_target, m_phase, m_cnt, m_hold;
  bit       m_pend, m_pc;
  bit [3:0] hist;
  bit [7:0] kprev;
  bit       tick, hit, accept, leave;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_page = 0; m_target = 0; m_phase = P_STEADY; m_cnt = 0; m_hold = 0;
      m_pend = 0; m_pc = 0; hist = 4'hF; kprev = 8'h00;
    end else begin
      // A VS fall sampled at edge k becomes a tick acted on at edge k+3.
      tick  = hist[3] && !hist[2];
      hit   = (keycode == 8'h28) && (kprev != 8'h28);
      hist  = {hist[2:0], VGA_VS};
      kprev = keycode;
      m_pc  = 0;
      leave = 0;
      if (m_phase == P_STEADY) begin
        accept = hit && (m_page < 2 || m_hold >= HOLD);
        if (m_page == 0) begin
          if (tick && m_pend) begin m_target = 1; leave = 1; end
        end else if (m_page == 1) begin
          if (tick && win) begin m_target = 2; leave = 1; end
          else if (tick && lose) begin m_target = 3; leave = 1; end
        end else if (tick) begin
          if (m_hold < HOLD) m_hold++;
          else if (m_pend) begin m_target = 0; leave = 1; end
        end
        if (leave) begin m_phase = P_OUT; m_cnt = 0; m_pend = 0; end
        else if (accept) m_pend = 1;
      end else if (m_phase == P_OUT) begin
        if (tick) begin
          if (m_cnt == F - 1) begin
            m_page = m_target; m_pc = 1; m_cnt = 0; m_phase = P_IN;
          end else m_cnt++;
        end
      end else begin
        if (tick) begin
          if (m_cnt == F - 1) begin
            m_phase = P_STEADY; m_cnt = 0; m_hold = 0; m_pend = 0;
          end else m_cnt++;
        end
      end
    end
  end

  function automatic int exp_level();
    if (m_phase == P_OUT) return (m_cnt * 8) / F;
    if (m_phase == P_IN)  return 7 - (m_cnt * 8) / F;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge Clk);
    check("status", int'(status), 1 << m_page);
    check("fade_level", int'(fade_level), exp_level());
    check("page_change", int'(page_change), int'(m_pc));
    check("game_rst", int'(game_rst), (m_phase == P_STEADY && m_page == 1) ? 0 : 1);
    if (page_change) pc_count++;
  end

  task automatic rand_step();
    int r;
    r = $urandom_range(99);
    if (r < 10)      keycode = 8'h28;
    else if (r < 15) keycode = 8'($urandom);
    else if (r < 60) keycode = keycode;
    else             keycode = 8'h00;
    win  = ($urandom_range(149) == 0);
    lose = ($urandom_range(149) == 0);
  endtask

  task automatic run_frames(input int n);
    int lo, hi;
    for (int f = 0; f < n; f++) begin
      lo = $urandom_range(4, 1);
      hi = $urandom_range(20, 8);
      for (int c = 0; c < lo; c++) begin
        @(negedge Clk); VGA_VS = 1'b0; if (rand_in) rand_step();
      end
      for (int c = 0; c < hi; c++) begin
        @(negedge Clk); VGA_VS = 1'b1; if (rand_in) rand_step();
      end
    end
  endtask

  task automatic press();
    repeat ($urandom_range(3, 1)) @(negedge Clk);
    keycode = 8'h28;
    @(negedge Clk);
    keycode = 8'h00;
  endtask

  int pc_before;

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk); #1;
    check("rst_status", int'(status), 1);
    check("rst_fade", int'(fade_level), 0);
    check("rst_game_rst", int'(game_rst), 1);

    run_frames(3);
    check("idle_status", int'(status), 1);
    check("idle_pc_count", pc_count, 0);

    // TITLE -> PLAY
    press();
    run_frames(1);
    run_frames(31);
    check("fo_end_level", int'(fade_level), 7);
    check("fo_end_status", int'(status), 1);
    run_frames(1);
    check("switch_status", int'(status), 2);
    check("switch_pc_count", pc_count, 1);
    run_frames(31);
    check("fi_end_level", int'(fade_level), 0);
    check("fi_end_game_rst", int'(game_rst), 1);
    run_frames(1);
    check("play_game_rst", int'(game_rst), 0);

    // win and lose together -> WIN
    @(negedge Clk); win = 1'b1; lose = 1'b1;
    run_frames(1);
    win = 1'b0; lose = 1'b0;
    run_frames(64);
    check("win_status", int'(status), 4);
    check("win_game_rst", int'(game_rst), 1);

    // Early key ignored, late key accepted
    run_frames(50);
    press();
    run_frames(80);
    check("win_early_key", int'(status), 4);
    check("win_early_level", int'(fade_level), 0);
    press();
    run_frames(33);
    check("win_to_title", int'(status), 1);
    run_frames(32);

    // Held key fires once
    pc_before = pc_count;
    @(negedge Clk); keycode = 8'h28;
    run_frames(200);
    keycode = 8'h00;
    check("hold_pc_delta", pc_count - pc_before, 1);
    check("hold_status", int'(status), 2);
    check("hold_game_rst", int'(game_rst), 0);

    // Reset in the middle of a fade-out
    @(negedge Clk); lose = 1'b1;
    run_frames(1);
    lose = 1'b0;
    run_frames(15);
    check("mid_fade_level", int'(fade_level), 3);
    @(negedge Clk); #5 Reset_n = 1'b0; #1;
    check("arst_status", int'(status), 1);
    check("arst_fade", int'(fade_level), 0);
    check("arst_game_rst", int'(game_rst), 1);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Random traffic
    rand_in = 1'b1;
    run_frames(300);
    rand_in = 1'b0;
    keycode = 8'h00; win = 1'b0; lose = 1'b0;
    run_frames(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
